dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_lane_fmt.sv | 45 ++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    // Access size encoding as seen on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Arbiter FSM states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Request attributes captured at accept time (address kept separately
    // because its width is a module parameter).
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              uns;
        logic [DATA_W-1:0] wdata;
    } req_attr_t;

    // Misaligned or reserved-size access.
    function automatic logic access_err(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte enables, error flag and load extension.
// Ports:
//   we, size, uns, addr_lo - registered request attributes
//   mem_rdata              - raw read data from memory
//   bwe_c                  - byte enables (0 for loads and errors)
//   err_c                  - misaligned / reserved-size flag
//   rdata_c                - extended load data (0 for stores and errors)
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic              we,
    input  size_e             size,
    input  logic              uns,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [BE_W-1:0]   bwe_c,
    output logic              err_c,
    output logic [DATA_W-1:0] rdata_c
);

    // Data is right-aligned on both paths, so only the size picks lanes.
    always_comb begin
        bwe_c   = '0;
        rdata_c = '0;
        err_c   = access_err(size, addr_lo);
        if (!err_c) begin
            if (we) begin
                case (size)
                    SZ_BYTE: bwe_c = 4'b0001;
                    SZ_HALF: bwe_c = 4'b0011;
                    SZ_WORD: bwe_c = 4'b1111;
                    default: bwe_c = 4'b0000;
                endcase
            end else begin
                case (size)
                    SZ_BYTE: rdata_c = {{24{~uns & mem_rdata[7]}},  mem_rdata[7:0]};
                    SZ_HALF: rdata_c = {{16{~uns & mem_rdata[15]}}, mem_rdata[15:0]};
                    SZ_WORD: rdata_c = mem_rdata;
                    default: rdata_c = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a shared data memory.
// Ports:
//   clk, rst                        - clock, async active-low reset
//   req_valid/ready/addr/we/size/
//   req_unsigned/req_wdata          - per-requester request (0 = LSU, 1 = debug)
//   resp_valid, resp_rdata, resp_err- registered one-cycle response
//   mem_addr, mem_bwe, mem_wdata    - memory write/address port
//   mem_rdata                       - combinational memory read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]                    req_we,
    input  logic [NUM_REQ-1:0][1:0]               req_size,
    input  logic [NUM_REQ-1:0]                    req_unsigned,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [DATA_W-1:0]                     resp_rdata,
    output logic                                  resp_err,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    output logic [BE_W-1:0]                       mem_bwe,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic [DATA_W-1:0]                     mem_rdata
);

    state_e                   state_q, state_d;
    logic                     gnt_c;
    logic                     accept_c;
    logic                     last_q;
    logic                     owner_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    req_attr_t                attr_q;
    logic [BE_W-1:0]          bwe_c;
    logic                     err_c;
    logic [DATA_W-1:0]        rdata_c;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        gnt_c = 1'b0;
        if (&req_valid) gnt_c = ~last_q;
        else            gnt_c = req_valid[1];
    end

    // FSM next state and combinational ready; ready is held off in reset.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst && (|req_valid)) begin
                    req_ready = NUM_REQ'(1) << gnt_c;
                    accept_c  = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Accepted request capture and round-robin history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            attr_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (accept_c) begin
            addr_q  <= req_addr[gnt_c];
            attr_q  <= '{we:    req_we[gnt_c],
                         size:  size_e'(req_size[gnt_c]),
                         uns:   req_unsigned[gnt_c],
                         wdata: req_wdata[gnt_c]};
            owner_q <= gnt_c;
            last_q  <= gnt_c;
        end
    end

    dmem_lane_fmt u_lane_fmt (
        .we        (attr_q.we),
        .size      (attr_q.size),
        .uns       (attr_q.uns),
        .addr_lo   (addr_q[1:0]),
        .mem_rdata (mem_rdata),
        .bwe_c     (bwe_c),
        .err_c     (err_c),
        .rdata_c   (rdata_c)
    );

    // Response captured on the edge leaving ACCESS; valid/err last one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            if (state_q == ST_ACCESS) begin
                resp_valid <= NUM_REQ'(1) << owner_q;
                resp_err   <= err_c;
                resp_rdata <= rdata_c;
            end
        end
    end

    // Memory port; async reset of state/regs zeroes these immediately.
    assign mem_addr  = addr_q;
    assign mem_wdata = attr_q.wdata;
    assign mem_bwe   = (state_q == ST_ACCESS) ? bwe_c : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-array memory and a
// spec-level reference model of loads/stores and round-robin order.
module tb_dmem_arbiter;

    localparam int AW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid, req_ready, req_we, req_unsigned, resp_valid;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][1:0]      req_size;
    logic [1:0][31:0]     req_wdata;
    logic [31:0]          resp_rdata, mem_wdata, mem_rdata;
    logic                 resp_err;
    logic [AW-1:0]        mem_addr;
    logic [3:0]           mem_bwe;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_bwe      (mem_bwe),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = {mem[8'(mem_addr + 8'd3)], mem[8'(mem_addr + 8'd2)],
                        mem[8'(mem_addr + 8'd1)], mem[mem_addr]};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (mem_bwe[k]) mem[8'(mem_addr + 8'(k))] <= mem_wdata[8*k +: 8];
    end

    // Expected behaviour straight from the access rules.
    task automatic model(input logic [7:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, output logic err, output logic [3:0] bwe,
                         output logic [31:0] rd);
        int nb;
        logic [31:0] v;
        nb  = 1 << sz;
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        bwe = 4'd0;
        rd  = 32'd0;
        if (!err && we) bwe = 4'((1 << nb) - 1);
        if (!err && !we) begin
            v = 32'd0;
            for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[8'(a + 8'(k))]) << (8 * k));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
        end
    endtask

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int nb;
        nb = 1 << sz;
        for (int k = 0; k < nb; k++) ref_mem[8'(a + 8'(k))] = wd[8*k +: 8];
    endtask

    // One isolated request from a single requester, checked end to end.
    task automatic issue(input int idx, input logic [7:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, output logic [31:0] got);
        logic e_err;
        logic [3:0] e_bwe;
        logic [31:0] e_rd;
        int n;
        model(a, we, sz, uns, e_err, e_bwe, e_rd);
        @(posedge clk); #1;
        req_valid         = 2'b00;
        req_valid[idx]    = 1'b1;
        req_addr[idx]     = a;
        req_we[idx]       = we;
        req_size[idx]     = sz;
        req_unsigned[idx] = uns;
        req_wdata[idx]    = wd;
        @(negedge clk);
        n = 0;
        while (req_ready == 2'b00 && n < 4) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 2'(1 << idx)) begin
            errors++; $display("FAIL ready req%0d: got %b expected %b", idx, req_ready, 2'(1 << idx));
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (mem_bwe !== e_bwe) begin
            errors++; $display("FAIL bwe a=%h sz=%0d we=%b: got %b expected %b", a, sz, we, mem_bwe, e_bwe);
        end
        checks++;
        if (mem_addr !== a || req_ready !== 2'b00) begin
            errors++; $display("FAIL access addr/ready: got %h/%b expected %h/00", mem_addr, req_ready, a);
        end
        if (we) begin
            checks++;
            if (mem_wdata !== wd) begin
                errors++; $display("FAIL wdata: got %h expected %h", mem_wdata, wd);
            end
        end
        @(negedge clk);
        got = resp_rdata;
        checks++;
        if (resp_valid !== 2'(1 << idx) || resp_err !== e_err || resp_rdata !== e_rd || mem_bwe !== 4'd0) begin
            errors++;
            $display("FAIL resp a=%h sz=%0d we=%b: got v=%b e=%b d=%h bwe=%b expected v=%b e=%b d=%h bwe=0000",
                     a, sz, we, resp_valid, resp_err, resp_rdata, mem_bwe, 2'(1 << idx), e_err, e_rd);
        end
        if (we && !e_err) ref_store(a, sz, wd);
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++; $display("FAIL resp pulse width: got %b expected 00", resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b11;
        req_we = 2'b11;
        req_size = {2'd2, 2'd2};
        req_addr = {8'h10, 8'h20};
        req_wdata = {32'h1111_1111, 32'h2222_2222};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset ctl: got ready=%b valid=%b err=%b expected 00/00/0", req_ready, resp_valid, resp_err);
        end
        checks++;
        if (resp_rdata !== 32'd0 || mem_bwe !== 4'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset data: got rd=%h bwe=%b a=%h wd=%h expected zeros", resp_rdata, mem_bwe, mem_addr, mem_wdata);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_rd [2];
        logic d_err;
        logic [3:0] d_bwe;
        int last, g_exp;
        @(posedge clk); #1;
        req_addr[0] = 8'h10; req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[1] = 8'h21; req_we[1] = 1'b0; req_size[1] = 2'd0; req_unsigned[1] = 1'b0;
        model(8'h10, 1'b0, 2'd2, 1'b0, d_err, d_bwe, exp_rd[0]);
        model(8'h21, 1'b0, 2'd0, 1'b0, d_err, d_bwe, exp_rd[1]);
        req_valid = 2'b11;
        last = 1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            g_exp = 1 - last;
            last  = g_exp;
            checks++;
            if (req_ready !== 2'(1 << g_exp)) begin
                errors++; $display("FAIL rr grant %0d: got %b expected %b", g, req_ready, 2'(1 << g_exp));
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
                errors++; $display("FAIL rr access %0d: got ready=%b valid=%b expected 00/00", g, req_ready, resp_valid);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (resp_valid !== 2'(1 << g_exp) || resp_rdata !== exp_rd[g_exp] || resp_err !== 1'b0) begin
                errors++; $display("FAIL rr resp %0d: got v=%b d=%h e=%b expected v=%b d=%h e=0",
                                   g, resp_valid, resp_rdata, resp_err, 2'(1 << g_exp), exp_rd[g_exp]);
            end
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] got;
        issue(0, 8'd8, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, got);
        issue(0, 8'd8, 1'b0, 2'd2, 1'b0, 32'd0, got);
        checks++;
        if (got !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word load: got %h expected deadbeef", got);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] got;
        issue(0, 8'd5, 1'b1, 2'd0, 1'b0, 32'h0000_0080, got);
        issue(1, 8'd5, 1'b0, 2'd0, 1'b0, 32'd0, got);
        checks++;
        if (got !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL signed byte: got %h expected ffffff80", got);
        end
        issue(0, 8'd5, 1'b0, 2'd0, 1'b1, 32'd0, got);
        checks++;
        if (got !== 32'h0000_0080) begin
            errors++; $display("FAIL unsigned byte: got %h expected 00000080", got);
        end
        issue(1, 8'd6, 1'b1, 2'd1, 1'b0, 32'h0000_1234, got);
        issue(0, 8'd6, 1'b0, 2'd1, 1'b1, 32'd0, got);
        checks++;
        if (got !== 32'h0000_1234) begin
            errors++; $display("FAIL half load: got %h expected 00001234", got);
        end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        issue(0, 8'd6, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, got);
        issue(1, 8'd3, 1'b0, 2'd1, 1'b0, 32'd0, got);
        issue(0, 8'd0, 1'b1, 2'd3, 1'b0, 32'h5555_AAAA, got);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[6 + k] !== ref_mem[6 + k]) begin
                errors++; $display("FAIL err mem[%0d]: got %h expected %h", 6 + k, mem[6 + k], ref_mem[6 + k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int i = 0; i < 40; i++)
            issue(int'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 1'($urandom),
                  2'($urandom), 1'($urandom), $urandom, got);
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] old_b;
        old_b = ref_mem[8'h40];
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_addr[0] = 8'h40; req_we[0] = 1'b1; req_size[0] = 2'd0; req_wdata[0] = 32'(~old_b);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL abort setup ready: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_bwe !== 4'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0 || req_ready !== 2'b00 ||
            resp_valid !== 2'b00 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++; $display("FAIL abort outputs: got bwe=%b a=%h wd=%h rdy=%b v=%b e=%b d=%h expected zeros",
                               mem_bwe, mem_addr, mem_wdata, req_ready, resp_valid, resp_err, resp_rdata);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b00) begin
                errors++; $display("FAIL abort resp: got %b expected 00", resp_valid);
            end
        end
        checks++;
        if (mem[8'h40] !== old_b) begin
            errors++; $display("FAIL abort mem: got %h expected %h", mem[8'h40], old_b);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req_we = 2'b00;
        req_size = {2'd0, 2'd0};
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL post-reset tie: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = 2'b00; req_we = 2'b00; req_unsigned = 2'b00;
        req_addr = '0; req_size = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_round_robin();
        test_word();
        test_byte_half();
        test_errors();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
